// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - shared definitions for the divider sequencer
package cpu_defs;

    localparam int DIV_DW = 32;

    typedef enum logic [1:0] {
        DIV_IDLE  = 2'd0,
        DIV_ISSUE = 2'd1,
        DIV_WAIT  = 2'd2,
        DIV_DONE  = 2'd3
    } div_state_t;

    // IP result word carries the quotient in the upper half, remainder in the lower
    function automatic logic [DIV_DW-1:0] dout_quo(input logic [2*DIV_DW-1:0] dout);
        return dout[2*DIV_DW-1:DIV_DW];
    endfunction

    function automatic logic [DIV_DW-1:0] dout_rem(input logic [2*DIV_DW-1:0] dout);
        return dout[DIV_DW-1:0];
    endfunction

endpackage

// File: rtl/div_ctrl_if.sv
// rtl/div_ctrl_if.sv - operand/result stream handshakes to the signed and unsigned divider IPs
interface div_ctrl_if;
    import cpu_defs::*;

    logic                  s_dvd_tvalid;
    logic                  s_dvs_tvalid;
    logic                  u_dvd_tvalid;
    logic                  u_dvs_tvalid;
    logic                  s_dvd_tready;
    logic                  s_dvs_tready;
    logic                  u_dvd_tready;
    logic                  u_dvs_tready;
    logic [DIV_DW-1:0]     dvd_tdata;
    logic [DIV_DW-1:0]     dvs_tdata;
    logic                  s_dout_tvalid;
    logic                  u_dout_tvalid;
    logic                  s_dout_tready;
    logic                  u_dout_tready;
    logic [2*DIV_DW-1:0]   s_dout_tdata;
    logic [2*DIV_DW-1:0]   u_dout_tdata;

    modport master (
        output s_dvd_tvalid, s_dvs_tvalid, u_dvd_tvalid, u_dvs_tvalid,
        output dvd_tdata, dvs_tdata, s_dout_tready, u_dout_tready,
        input  s_dvd_tready, s_dvs_tready, u_dvd_tready, u_dvs_tready,
        input  s_dout_tvalid, u_dout_tvalid, s_dout_tdata, u_dout_tdata
    );

    modport slave (
        input  s_dvd_tvalid, s_dvs_tvalid, u_dvd_tvalid, u_dvs_tvalid,
        input  dvd_tdata, dvs_tdata, s_dout_tready, u_dout_tready,
        output s_dvd_tready, s_dvs_tready, u_dvd_tready, u_dvs_tready,
        output s_dout_tvalid, u_dout_tvalid, s_dout_tdata, u_dout_tdata
    );

endinterface

// File: rtl/div_axis_chan.sv
// rtl/div_axis_chan.sv - one operand channel: holds tvalid until accepted, then remembers acceptance
module div_axis_chan (
    input  logic clk,
    input  logic resetn,
    input  logic arm,
    input  logic tready,
    output logic tvalid,
    output logic accepted
);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tvalid   <= 1'b0;
            accepted <= 1'b0;
        end else if (arm) begin
            tvalid   <= 1'b1;
            accepted <= 1'b0;
        end else if (tvalid && tready) begin
            tvalid   <= 1'b0;
            accepted <= 1'b1;
        end
    end

endmodule

// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - sequences one EX div/mod request through the signed or unsigned divider IP
module div_ctrl
    import cpu_defs::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              div_req,
    input  logic              div_signed,
    input  logic              div_mod,
    input  logic [DIV_DW-1:0] src1,
    input  logic [DIV_DW-1:0] src2,
    input  logic              ex_leave,
    input  logic              flush,
    div_ctrl_if.master        ip,
    output logic              div_done,
    output logic [DIV_DW-1:0] div_result,
    output logic              busy
);

    div_state_t        state;
    div_state_t        state_nxt;
    logic              sel_signed;
    logic              sel_mod;
    logic              killed;
    logic [DIV_DW-1:0] dvd_q;
    logic [DIV_DW-1:0] dvs_q;

    logic              accept;
    logic              dvd_tvalid, dvs_tvalid;
    logic              dvd_acc, dvs_acc;
    logic              dvd_tready, dvs_tready;
    logic              dvd_done, dvs_done;
    logic                dout_tvalid;
    logic [2*DIV_DW-1:0] dout_tdata;
    logic              dout_fire;

    assign accept      = (state == DIV_IDLE) && div_req && !flush;
    assign dvd_tready  = sel_signed ? ip.s_dvd_tready : ip.u_dvd_tready;
    assign dvs_tready  = sel_signed ? ip.s_dvs_tready : ip.u_dvs_tready;
    assign dout_tvalid = sel_signed ? ip.s_dout_tvalid : ip.u_dout_tvalid;
    assign dout_tdata  = sel_signed ? ip.s_dout_tdata  : ip.u_dout_tdata;
    assign dout_fire   = (state == DIV_WAIT) && dout_tvalid;

    // A channel counts as done in the very cycle its handshake happens
    assign dvd_done = dvd_acc || (dvd_tvalid && dvd_tready);
    assign dvs_done = dvs_acc || (dvs_tvalid && dvs_tready);

    div_axis_chan u_dvd_chan (
        .clk      (clk),
        .resetn   (resetn),
        .arm      (accept),
        .tready   (dvd_tready),
        .tvalid   (dvd_tvalid),
        .accepted (dvd_acc)
    );

    div_axis_chan u_dvs_chan (
        .clk      (clk),
        .resetn   (resetn),
        .arm      (accept),
        .tready   (dvs_tready),
        .tvalid   (dvs_tvalid),
        .accepted (dvs_acc)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= DIV_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            DIV_IDLE: begin
                if (accept) begin
                    state_nxt = DIV_ISSUE;
                end
            end
            DIV_ISSUE: begin
                if (dvd_done && dvs_done) begin
                    state_nxt = DIV_WAIT;
                end
            end
            DIV_WAIT: begin
                // A cancelled request still drains the IP result before idling
                if (dout_tvalid) begin
                    state_nxt = (killed || flush) ? DIV_IDLE : DIV_DONE;
                end
            end
            DIV_DONE: begin
                if (ex_leave || flush) begin
                    state_nxt = DIV_IDLE;
                end
            end
            default: state_nxt = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sel_signed <= 1'b0;
            sel_mod    <= 1'b0;
            killed     <= 1'b0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            div_result <= '0;
        end else begin
            if (accept) begin
                sel_signed <= div_signed;
                sel_mod    <= div_mod;
                killed     <= 1'b0;
                dvd_q      <= src1;
                dvs_q      <= src2;
            end else if (flush && (state == DIV_ISSUE || state == DIV_WAIT)) begin
                killed <= 1'b1;
            end
            if (dout_fire) begin
                div_result <= sel_mod ? dout_rem(dout_tdata) : dout_quo(dout_tdata);
            end
        end
    end

    assign ip.s_dvd_tvalid  = dvd_tvalid && sel_signed;
    assign ip.s_dvs_tvalid  = dvs_tvalid && sel_signed;
    assign ip.u_dvd_tvalid  = dvd_tvalid && !sel_signed;
    assign ip.u_dvs_tvalid  = dvs_tvalid && !sel_signed;
    assign ip.dvd_tdata     = dvd_q;
    assign ip.dvs_tdata     = dvs_q;
    assign ip.s_dout_tready = (state == DIV_WAIT) && sel_signed;
    assign ip.u_dout_tready = (state == DIV_WAIT) && !sel_signed;

    assign div_done = (state == DIV_DONE) && !killed;
    assign busy     = (state != DIV_IDLE);

endmodule

// File: tb/tb_div_ctrl.sv
// tb/tb_div_ctrl.sv - directed self-checking bench for div_ctrl
module tb_div_ctrl;
    import cpu_defs::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        div_req;
    logic        div_signed;
    logic        div_mod;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        ex_leave;
    logic        flush;
    logic        div_done;
    logic [31:0] div_result;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    div_ctrl_if ipb ();

    div_ctrl dut (
        .clk        (clk),
        .resetn     (resetn),
        .div_req    (div_req),
        .div_signed (div_signed),
        .div_mod    (div_mod),
        .src1       (src1),
        .src2       (src2),
        .ex_leave   (ex_leave),
        .flush      (flush),
        .ip         (ipb),
        .div_done   (div_done),
        .div_result (div_result),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_readys(input logic v);
        ipb.s_dvd_tready = v;
        ipb.s_dvs_tready = v;
        ipb.u_dvd_tready = v;
        ipb.u_dvs_tready = v;
    endtask

    task automatic drive_dout(input logic sgn, input logic v, input logic [63:0] data);
        if (sgn) begin
            ipb.s_dout_tvalid = v;
            ipb.s_dout_tdata  = data;
        end else begin
            ipb.u_dout_tvalid = v;
            ipb.u_dout_tdata  = data;
        end
    endtask

    function automatic logic [3:0] tvalids();
        return {ipb.s_dvd_tvalid, ipb.s_dvs_tvalid, ipb.u_dvd_tvalid, ipb.u_dvs_tvalid};
    endfunction

    task automatic start_req(input logic sgn, input logic md, input logic [31:0] a, input logic [31:0] b);
        div_req    = 1'b1;
        div_signed = sgn;
        div_mod    = md;
        src1       = a;
        src2       = b;
        tick();
    endtask

    task automatic check_issue(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b);
        check({tag, " tvalid"}, tvalids(), sgn ? 4'b1100 : 4'b0011);
        check({tag, " dvd"}, ipb.dvd_tdata, a);
        check({tag, " dvs"}, ipb.dvs_tdata, b);
        check({tag, " busy"}, busy, 1'b1);
    endtask

    task automatic finish_div(input string tag, input logic sgn, input int latency,
                              input logic [63:0] dout, input logic [31:0] exp);
        check({tag, " wait tvalid"}, tvalids(), 4'b0000);
        check({tag, " wait tready"}, {ipb.s_dout_tready, ipb.u_dout_tready}, sgn ? 2'b10 : 2'b01);
        for (int i = 0; i < latency; i++) begin
            tick();
            check({tag, " early done"}, div_done, 1'b0);
        end
        drive_dout(sgn, 1'b1, dout);
        tick();
        drive_dout(sgn, 1'b0, 64'h0);
        check({tag, " done"}, div_done, 1'b1);
        check({tag, " result"}, div_result, exp);
    endtask

    task automatic leave(input string tag);
        ex_leave = 1'b1;
        div_req  = 1'b0;
        tick();
        ex_leave = 1'b0;
        check({tag, " idle busy"}, busy, 1'b0);
        check({tag, " idle done"}, div_done, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn     = 1'b0;
        div_req    = 1'b0;
        div_signed = 1'b0;
        div_mod    = 1'b0;
        src1       = '0;
        src2       = '0;
        ex_leave   = 1'b0;
        flush      = 1'b0;
        set_readys(1'b0);
        drive_dout(1'b1, 1'b0, 64'h0);
        drive_dout(1'b0, 1'b0, 64'h0);
        tick();
        tick();
        check("rst busy", busy, 1'b0);
        check("rst done", div_done, 1'b0);
        check("rst result", div_result, 32'h0);
        check("rst tvalid", tvalids(), 4'b0000);
        check("rst tready", {ipb.s_dout_tready, ipb.u_dout_tready}, 2'b00);
        check("rst operands", {ipb.dvd_tdata, ipb.dvs_tdata}, 64'h0);
        resetn = 1'b1;
        tick();

        // signed 7/2, IP latency 10
        set_readys(1'b1);
        start_req(1'b1, 1'b0, 32'd7, 32'd2);
        check_issue("sdiv", 1'b1, 32'd7, 32'd2);
        tick();
        finish_div("sdiv", 1'b1, 10, {32'd3, 32'd1}, 32'd3);
        leave("sdiv");

        // signed -7 mod 2
        start_req(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2);
        check_issue("smod", 1'b1, 32'hFFFF_FFF9, 32'd2);
        tick();
        finish_div("smod", 1'b1, 3, {32'hFFFF_FFFD, 32'hFFFF_FFFF}, 32'hFFFF_FFFF);
        leave("smod");

        // unsigned div, then DONE held for 5 cycles, then back-to-back request
        start_req(1'b0, 1'b0, 32'hFFFF_FFFE, 32'd2);
        check_issue("udiv", 1'b0, 32'hFFFF_FFFE, 32'd2);
        tick();
        finish_div("udiv", 1'b0, 2, {32'h7FFF_FFFF, 32'h0}, 32'h7FFF_FFFF);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold done", div_done, 1'b1);
            check("hold result", div_result, 32'h7FFF_FFFF);
        end
        ex_leave = 1'b1;
        tick();
        ex_leave = 1'b0;
        check("b2b idle", busy, 1'b0);
        start_req(1'b0, 1'b0, 32'd45, 32'd6);
        check_issue("b2b", 1'b0, 32'd45, 32'd6);
        tick();
        finish_div("b2b", 1'b0, 1, {32'd7, 32'd3}, 32'd7);
        leave("b2b");

        // staggered operand readys
        set_readys(1'b0);
        start_req(1'b1, 1'b0, 32'd20, 32'd3);
        check_issue("stag", 1'b1, 32'd20, 32'd3);
        ipb.s_dvd_tready = 1'b1;
        tick();
        ipb.s_dvd_tready = 1'b0;
        check("stag t2 tvalid", tvalids(), 4'b0100);
        check("stag t2 tready", ipb.s_dout_tready, 1'b0);
        tick();
        check("stag t3 tvalid", tvalids(), 4'b0100);
        tick();
        check("stag t4 tvalid", tvalids(), 4'b0100);
        check("stag t4 tready", ipb.s_dout_tready, 1'b0);
        ipb.s_dvs_tready = 1'b1;
        tick();
        ipb.s_dvs_tready = 1'b0;
        finish_div("stag", 1'b1, 2, {32'd6, 32'd2}, 32'd6);
        leave("stag");
        set_readys(1'b1);

        // flush in WAIT with a new request held during the drain
        start_req(1'b0, 1'b0, 32'd50, 32'd5);
        check_issue("kill", 1'b0, 32'd50, 32'd5);
        tick();
        flush   = 1'b1;
        div_req = 1'b0;
        tick();
        flush = 1'b0;
        div_req    = 1'b1;
        div_signed = 1'b1;
        div_mod    = 1'b1;
        src1       = 32'd17;
        src2       = 32'd5;
        check("kill busy", busy, 1'b1);
        check("kill tready", {ipb.s_dout_tready, ipb.u_dout_tready}, 2'b01);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("kill drain done", div_done, 1'b0);
            check("kill drain tvalid", tvalids(), 4'b0000);
        end
        drive_dout(1'b0, 1'b1, {32'd10, 32'd0});
        tick();
        drive_dout(1'b0, 1'b0, 64'h0);
        check("kill drained busy", busy, 1'b0);
        check("kill drained done", div_done, 1'b0);
        tick();
        check_issue("post kill", 1'b1, 32'd17, 32'd5);
        tick();
        finish_div("post kill", 1'b1, 2, {32'd3, 32'd2}, 32'd2);
        leave("post kill");

        // flush coincident with the result handshake
        start_req(1'b0, 1'b1, 32'd9, 32'd4);
        check_issue("kill same", 1'b0, 32'd9, 32'd4);
        tick();
        flush   = 1'b1;
        div_req = 1'b0;
        drive_dout(1'b0, 1'b1, {32'd2, 32'd1});
        tick();
        flush = 1'b0;
        drive_dout(1'b0, 1'b0, 64'h0);
        check("kill same busy", busy, 1'b0);
        check("kill same done", div_done, 1'b0);
        tick();
        check("kill same stays idle", busy, 1'b0);

        // flush in DONE
        start_req(1'b0, 1'b0, 32'd9, 32'd4);
        tick();
        finish_div("flush done", 1'b0, 1, {32'd2, 32'd1}, 32'd2);
        flush   = 1'b1;
        div_req = 1'b0;
        tick();
        flush = 1'b0;
        check("flush done busy", busy, 1'b0);
        check("flush done done", div_done, 1'b0);

        // asynchronous reset mid-WAIT
        start_req(1'b1, 1'b0, 32'd7, 32'd2);
        tick();
        check("pre rst wait", ipb.s_dout_tready, 1'b1);
        #2;
        resetn  = 1'b0;
        div_req = 1'b0;
        #1;
        check("arst busy", busy, 1'b0);
        check("arst done", div_done, 1'b0);
        check("arst result", div_result, 32'h0);
        check("arst tready", {ipb.s_dout_tready, ipb.u_dout_tready}, 2'b00);
        check("arst tvalid", tvalids(), 4'b0000);
        check("arst operands", {ipb.dvd_tdata, ipb.dvs_tdata}, 64'h0);
        tick();
        resetn = 1'b1;
        tick();
        start_req(1'b0, 1'b1, 32'd100, 32'd7);
        check_issue("umod", 1'b0, 32'd100, 32'd7);
        tick();
        finish_div("umod", 1'b0, 4, {32'd14, 32'd2}, 32'd2);
        leave("umod");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Sequencer between the EX stage and the two divider IPs (signed `mydiv`, unsigned `unsigned_div`). It accepts one div/mod request from EX and drives the AXI-stream operand and result handshakes of the selected IP. It captures and holds the 32-bit quotient or remainder, and raises `div_done`, which EX uses as its ready-to-go term for divide instructions. A flush cancels the request, and any in-flight IP transaction is drained silently.

## Interface
- `DW`, 32, operand/result width; IP dout is `2*DW`, with quotient in `[2*DW-1:DW]` and remainder in `[DW-1:0]`.
- `clk` in 1: rising-edge clock.
- `resetn` in 1: reset, asynchronous active-low.
- `div_req` in 1: EX holds a valid div/mod instruction; stable with operands until `ex_leave` or `flush`.
- `div_signed` in 1: 1 selects the signed IP, 0 the unsigned IP.
- `div_mod` in 1: 1 returns the remainder, 0 the quotient.
- `src1`, `src2` in DW: dividend, divisor.
- `ex_leave` in 1: EX advances this cycle (`div_done & MEM_allowin`).
- `flush` in 1: cancel the current request.
- `s_dvd_tvalid`, `u_dvd_tvalid` out 1: dividend valid to the signed/unsigned IP.
- `s_dvs_tvalid`, `u_dvs_tvalid` out 1: divisor valid.
- `s_dvd_tready`, `s_dvs_tready`, `u_dvd_tready`, `u_dvs_tready` in 1: IP operand ready.
- `dvd_tdata`, `dvs_tdata` out DW: registered operands, shared by both IPs.
- `s_dout_tvalid`, `u_dout_tvalid` in 1: IP result valid.
- `s_dout_tready`, `u_dout_tready` out 1: result ready.
- `s_dout_tdata`, `u_dout_tdata` in 2*DW: IP results.
- `div_done` out 1: result valid and held.
- `div_result` out DW: selected quotient/remainder.
- `busy` out 1: state is not IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If `div_req & ~flush`: latch `src1/src2/div_signed/div_mod`, clear `killed`, go to ISSUE.
- ISSUE:
  - Both tvalids of the selected IP are asserted; the other IP's tvalids stay 0.
  - Each channel's tvalid drops the cycle after its own `tvalid&tready`; the two channels complete independently, in either order.
  - When both are accepted, go to WAIT.
  - tvalid is never withdrawn before acceptance, even under flush.
- WAIT:
  - Selected `dout_tready`=1.
  - On `dout_tvalid`: capture `dout[2*DW-1:DW]` (`div_mod`=0) or `dout[DW-1:0]` (`div_mod`=1) into `div_result`.
  - Go to DONE, or to IDLE if `killed`.
- DONE:
  - `div_done`=1 and `div_result` held until `ex_leave` or `flush`, then go to IDLE.
- `flush` in ISSUE or WAIT sets `killed`. The sequence continues until the result is consumed, then returns to IDLE without asserting `div_done`.
- `flush` in IDLE or DONE forces IDLE.
- `div_req` during a killed drain waits; it is sampled only in IDLE.
- Divide-by-zero is passed to the IP unchanged; the result is whatever the IP returns.

## Timing
- Reset (async assert, sync deassert): state IDLE, all tvalid/tready 0, `div_done` 0, `div_result` 0, `busy` 0, `killed` 0, operand registers 0.
- Request sampled at cycle t, IP readys high:
  - tvalids high in cycle t+1 (ISSUE).
  - WAIT in cycle t+2.
  - With the dout handshake at cycle d, `div_done`=1 from cycle d+1.
- `ex_leave` in cycle u gives IDLE at u+1, and a new request is sampled at u+1. Minimum issue-to-issue spacing: 1 IDLE cycle.
- `ex_leave` and `flush` in the same DONE cycle: IDLE, no difference.
- `flush` and `dout_tvalid` in the same WAIT cycle: result consumed, go to IDLE, `div_done` stays 0.
- `div_done` never asserts in a cycle where `killed`=1.

## Structure
- Shared package `cpu_defs`: `div_state_t` encoding (IDLE/ISSUE/WAIT/DONE) and the quotient/remainder field slices of the dout word.
- One sub-module, `div_axis_chan`: a single operand channel's tvalid hold and accept flag (arm, `tvalid&tready` clear, `accepted` output). It is instantiated twice, for dividend and divisor; the IP selection is muxed outside it.

## Test plan
- Signed, `src1`=7, `src2`=2, `div_mod`=0, readys high, IP latency 10 -> `div_done` one cycle after dout handshake, `div_result`=3; `u_*` tvalids stay 0.
- Signed mod, `src1`=0xFFFFFFF9 (−7), `src2`=2 -> `div_result`=0xFFFFFFFF. Unsigned div 0xFFFFFFFE/2 -> 0x7FFFFFFF.
- Staggered readys: dividend tready in cycle t+1, divisor in t+4 -> dividend tvalid low from t+2, divisor tvalid high t+1..t+4, WAIT entered at t+5.
- `ex_leave` held 0 for 5 cycles in DONE -> `div_done` and `div_result` stable; `ex_leave`=1 -> IDLE next cycle. A back-to-back request is then sampled and completes with the correct result.
- `flush` in WAIT: IP result later consumed with `dout_tready`=1, `div_done` never 1, `busy` drops the cycle after consumption. A new `div_req` held during the drain issues only after IDLE.
- `resetn` low mid-WAIT -> all outputs 0 immediately, state IDLE; after release, a fresh request 100/7 unsigned mod -> 2.
